// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the hazard controller and the pipeline registers it steers.
package pipeline_ctrl_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int WDOG_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_RUN           = 2'd0,
        ST_MULDIV_WAIT   = 2'd1,
        ST_FLUSH_PENDING = 2'd2
    } ctrl_state_e;

    // Control fields carried by ID/EX; a bubble or flush loads all zeros.
    typedef struct packed {
        logic reg_write_en;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic muldiv_start;
    } stage_ctrl_t;

    localparam stage_ctrl_t NOP_CTRL        = '0;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: ID/EX hazard sources and memory stalls in, stage holds/bubble/flushes out.
interface pipeline_hazard_controller_if;
    import pipeline_ctrl_pkg::*;

    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic                 ex_mem_read;
    logic                 ex_reg_write_en;
    logic                 ex_branch_taken;
    logic                 ex_muldiv_start;
    logic                 muldiv_done;
    logic                 imem_busywait;
    logic                 dmem_busywait;

    logic                 pc_hold;
    logic                 if_id_hold;
    logic                 id_ex_hold;
    logic                 ex_mem_hold;
    logic                 id_ex_bubble;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 muldiv_error;
    logic [1:0]           ctrl_state;

    modport master (
        output id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_mem_read,
               ex_reg_write_en, ex_branch_taken, ex_muldiv_start, muldiv_done,
               imem_busywait, dmem_busywait,
        input  pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, id_ex_bubble,
               if_id_flush, id_ex_flush, muldiv_error, ctrl_state
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_mem_read,
               ex_reg_write_en, ex_branch_taken, ex_muldiv_start, muldiv_done,
               imem_busywait, dmem_busywait,
        output pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, id_ex_bubble,
               if_id_flush, id_ex_flush, muldiv_error, ctrl_state
    );

endinterface

// File: rtl/pipeline_hazard_controller_load_use.sv
// Combinational load-use detector: the ID instruction reads a register the EX load is about to write.
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_mem_read,
    input  logic                 ex_reg_write_en,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is never a real dependency.
    assign load_use = ex_mem_read && ex_reg_write_en && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, mul/div stalls with a watchdog.
// Optional STALL_CYCLES/FLUSH_COUNT statistics are enabled by defining HAZARD_STALL_COUNTERS_EN.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_MAX_CYCLES = 34
) (
    input  logic                          clk,
    input  logic                          reset,
    pipeline_hazard_controller_if.slave   hz
`ifdef HAZARD_STALL_COUNTERS_EN
    ,
    output logic [31:0]                   stall_cycles,
    output logic [31:0]                   flush_count
`endif
);

    localparam logic [WDOG_CNT_W-1:0] MAX_CNT = WDOG_CNT_W'(MULDIV_MAX_CYCLES);

    ctrl_state_e           state;
    ctrl_state_e           state_next;
    logic [WDOG_CNT_W-1:0] cnt;
    logic [WDOG_CNT_W-1:0] cnt_next;
    logic                  error_next;
    logic                  muldiv_error_q;
    logic                  mem_busy;
    logic                  load_use;
    logic                  hold_all;
    logic                  bubble;
    logic                  flush;

    load_use_detector u_load_use (
        .id_rs1          (hz.id_rs1),
        .id_rs2          (hz.id_rs2),
        .ex_rd           (hz.ex_rd),
        .id_uses_rs1     (hz.id_uses_rs1),
        .id_uses_rs2     (hz.id_uses_rs2),
        .ex_mem_read     (hz.ex_mem_read),
        .ex_reg_write_en (hz.ex_reg_write_en),
        .load_use        (load_use)
    );

    assign mem_busy = hz.imem_busywait | hz.dmem_busywait;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next = state;
        cnt_next   = cnt;
        error_next = 1'b0;
        hold_all   = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        case (state)
            ST_RUN: begin
                if (hz.ex_branch_taken) begin
                    if (mem_busy) state_next = ST_FLUSH_PENDING;
                    else          flush      = 1'b1;
                end else if (hz.ex_muldiv_start && !hz.muldiv_done) begin
                    hold_all   = 1'b1;
                    state_next = ST_MULDIV_WAIT;
                end else if (load_use && !mem_busy) begin
                    // A held ID/EX cannot take a bubble; it is inserted once memory releases.
                    bubble = 1'b1;
                end
            end
            ST_MULDIV_WAIT: begin
                if (hz.muldiv_done) begin
                    state_next = ST_RUN;
                end else begin
                    hold_all = 1'b1;
                    if (cnt == MAX_CNT) begin
                        error_next = 1'b1;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_FLUSH_PENDING: begin
                if (!mem_busy) begin
                    flush      = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase

        if (state_next == ST_RUN)  cnt_next = '0;
        else if (state == ST_RUN)  cnt_next = WDOG_CNT_W'(1);
        else if (cnt != '1)        cnt_next = cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values; reset is sampled on the edge.
        if (!reset) begin
            state          <= ST_RUN;
            cnt            <= '0;
            muldiv_error_q <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            muldiv_error_q <= error_next;
        end
    end

    // While reset is low the pipeline registers are forced to load NOPs and nothing is held.
    assign hz.pc_hold      = reset & (hold_all | bubble | mem_busy);
    assign hz.if_id_hold   = reset & (hold_all | bubble | mem_busy);
    assign hz.id_ex_hold   = reset & (hold_all | mem_busy);
    assign hz.ex_mem_hold  = reset & (hold_all | mem_busy);
    assign hz.id_ex_bubble = reset & bubble;
    assign hz.if_id_flush  = !reset | flush;
    assign hz.id_ex_flush  = !reset | flush;
    assign hz.muldiv_error = muldiv_error_q;
    assign hz.ctrl_state   = state;

`ifdef HAZARD_STALL_COUNTERS_EN
    logic any_stall;

    assign any_stall = hz.pc_hold | hz.if_id_hold | hz.id_ex_hold | hz.ex_mem_hold | hz.id_ex_bubble;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (any_stall)      stall_cycles <= stall_cycles + 32'd1;
            if (hz.id_ex_flush) flush_count  <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a default instance and a MULDIV_MAX_CYCLES=4 instance.
module tb_pipeline_hazard_controller;
    import pipeline_ctrl_pkg::*;

    // Output vector order: {pc, if_id, id_ex, ex_mem holds, bubble, if_id_flush, id_ex_flush}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_HOLD  = 7'b1111000;
    localparam logic [6:0] O_LU    = 7'b1100100;
    localparam logic [6:0] O_FLUSH = 7'b0000011;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write_en;
    logic       ex_branch_taken, ex_muldiv_start, muldiv_done;
    logic       imem_busywait, dmem_busywait;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller_if hz_a ();
    pipeline_hazard_controller_if hz_b ();

    assign hz_a.id_rs1 = id_rs1;                   assign hz_b.id_rs1 = id_rs1;
    assign hz_a.id_rs2 = id_rs2;                   assign hz_b.id_rs2 = id_rs2;
    assign hz_a.ex_rd = ex_rd;                     assign hz_b.ex_rd = ex_rd;
    assign hz_a.id_uses_rs1 = id_uses_rs1;         assign hz_b.id_uses_rs1 = id_uses_rs1;
    assign hz_a.id_uses_rs2 = id_uses_rs2;         assign hz_b.id_uses_rs2 = id_uses_rs2;
    assign hz_a.ex_mem_read = ex_mem_read;         assign hz_b.ex_mem_read = ex_mem_read;
    assign hz_a.ex_reg_write_en = ex_reg_write_en; assign hz_b.ex_reg_write_en = ex_reg_write_en;
    assign hz_a.ex_branch_taken = ex_branch_taken; assign hz_b.ex_branch_taken = ex_branch_taken;
    assign hz_a.ex_muldiv_start = ex_muldiv_start; assign hz_b.ex_muldiv_start = ex_muldiv_start;
    assign hz_a.muldiv_done = muldiv_done;         assign hz_b.muldiv_done = muldiv_done;
    assign hz_a.imem_busywait = imem_busywait;     assign hz_b.imem_busywait = imem_busywait;
    assign hz_a.dmem_busywait = dmem_busywait;     assign hz_b.dmem_busywait = dmem_busywait;

`ifdef HAZARD_STALL_COUNTERS_EN
    logic [31:0] stall_a, flush_a, stall_b, flush_b;
`endif

    pipeline_hazard_controller #(.MULDIV_MAX_CYCLES(34)) dut_a (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_a)
`ifdef HAZARD_STALL_COUNTERS_EN
        ,
        .stall_cycles (stall_a),
        .flush_count  (flush_a)
`endif
    );

    pipeline_hazard_controller #(.MULDIV_MAX_CYCLES(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_b)
`ifdef HAZARD_STALL_COUNTERS_EN
        ,
        .stall_cycles (stall_b),
        .flush_count  (flush_b)
`endif
    );

    function automatic logic [6:0] outs_a();
        return {hz_a.pc_hold, hz_a.if_id_hold, hz_a.id_ex_hold, hz_a.ex_mem_hold,
                hz_a.id_ex_bubble, hz_a.if_id_flush, hz_a.id_ex_flush};
    endfunction

    function automatic logic [6:0] outs_b();
        return {hz_b.pc_hold, hz_b.if_id_hold, hz_b.id_ex_hold, hz_b.ex_mem_hold,
                hz_b.id_ex_bubble, hz_b.if_id_flush, hz_b.id_ex_flush};
    endfunction

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0; ex_reg_write_en = 1'b0;
        ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0; muldiv_done = 1'b0;
        imem_busywait = 1'b0; dmem_busywait = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        ex_branch_taken = 1'b1;
        dmem_busywait   = 1'b1;
        @(negedge clk);
        total++;
        if (outs_a() !== O_FLUSH) begin bad++; $display("FAIL reset_outputs: got %b want %b", outs_a(), O_FLUSH); end
        tick();
        @(negedge clk);
        total++;
        if (hz_a.ctrl_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", hz_a.ctrl_state); end
        total++;
        if (hz_a.muldiv_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", hz_a.muldiv_error); end
        idle_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        // lw x5 in EX, add x6,x5,x1 in ID
        ex_mem_read = 1'b1; ex_reg_write_en = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs2 = 5'd1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        @(negedge clk);
        total++;
        if (outs_a() !== O_LU) begin bad++; $display("FAIL load_use_rs1: got %b want %b", outs_a(), O_LU); end
        tick();
        // bubble now in EX (all control zero)
        ex_mem_read = 1'b0; ex_reg_write_en = 1'b0; ex_rd = 5'd0;
        @(negedge clk);
        total++;
        if (outs_a() !== O_IDLE) begin bad++; $display("FAIL load_use_single_bubble: got %b want %b", outs_a(), O_IDLE); end
        total++;
        if (hz_a.ctrl_state !== 2'd0) begin bad++; $display("FAIL load_use_state: got %0d want 0", hz_a.ctrl_state); end
        tick();
        ex_mem_read = 1'b1; ex_reg_write_en = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd2; id_rs2 = 5'd9;
        @(negedge clk);
        total++;
        if (outs_a() !== O_LU) begin bad++; $display("FAIL load_use_rs2: got %b want %b", outs_a(), O_LU); end
        tick();
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        @(negedge clk);
        total++;
        if (outs_a() !== O_IDLE) begin bad++; $display("FAIL load_use_x0: got %b want %b", outs_a(), O_IDLE); end
        tick();
        ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; id_rs2 = 5'd3;
        @(negedge clk);
        total++;
        if (outs_a() !== O_IDLE) begin bad++; $display("FAIL load_use_rs1_unused: got %b want %b", outs_a(), O_IDLE); end
        tick();
        id_uses_rs1 = 1'b1; ex_reg_write_en = 1'b0;
        @(negedge clk);
        total++;
        if (outs_a() !== O_IDLE) begin bad++; $display("FAIL load_use_no_write: got %b want %b", outs_a(), O_IDLE); end
        tick();
        idle_inputs();
    endtask

    task automatic test_branch_over_load_use();
        do_reset();
        ex_mem_read = 1'b1; ex_reg_write_en = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1; ex_branch_taken = 1'b1;
        @(negedge clk);
        total++;
        if (outs_a() !== O_FLUSH) begin bad++; $display("FAIL branch_load_use: got %b want %b", outs_a(), O_FLUSH); end
        tick();
        idle_inputs();
        @(negedge clk);
        total++;
        if (hz_a.ctrl_state !== 2'd0) begin bad++; $display("FAIL branch_state: got %0d want 0", hz_a.ctrl_state); end
        tick();
    endtask

    task automatic test_mem_busy();
        do_reset();
        imem_busywait = 1'b1;
        @(negedge clk);
        total++;
        if (outs_a() !== O_HOLD) begin bad++; $display("FAIL imem_busy_hold: got %b want %b", outs_a(), O_HOLD); end
        tick();
        idle_inputs();
    endtask

    task automatic test_muldiv();
        int hold_cycles;
        do_reset();
        hold_cycles = 0;
        ex_muldiv_start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (outs_a() !== O_HOLD) begin bad++; $display("FAIL muldiv_hold[%0d]: got %b want %b", c, outs_a(), O_HOLD); end
            else hold_cycles++;
            tick();
        end
        muldiv_done = 1'b1;
        @(negedge clk);
        total++;
        if (outs_a() !== O_IDLE) begin bad++; $display("FAIL muldiv_done_release: got %b want %b", outs_a(), O_IDLE); end
        total++;
        if (hz_a.ctrl_state !== 2'd1) begin bad++; $display("FAIL muldiv_wait_state: got %0d want 1", hz_a.ctrl_state); end
        tick();
        ex_muldiv_start = 1'b0; muldiv_done = 1'b0;
        @(negedge clk);
        total++;
        if (hz_a.ctrl_state !== 2'd0) begin bad++; $display("FAIL muldiv_back_to_run: got %0d want 0", hz_a.ctrl_state); end
        total++;
        if (hold_cycles !== 5) begin bad++; $display("FAIL muldiv_hold_count: got %0d want 5", hold_cycles); end
        tick();
        // single-cycle result never stalls
        ex_muldiv_start = 1'b1; muldiv_done = 1'b1;
        @(negedge clk);
        total++;
        if (outs_a() !== O_IDLE) begin bad++; $display("FAIL muldiv_single_cycle: got %b want %b", outs_a(), O_IDLE); end
        tick();
        idle_inputs();
        @(negedge clk);
        total++;
        if (hz_a.ctrl_state !== 2'd0) begin bad++; $display("FAIL muldiv_single_state: got %0d want 0", hz_a.ctrl_state); end
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        ex_muldiv_start = 1'b1;
        @(negedge clk);
        total++;
        if (outs_b() !== O_HOLD) begin bad++; $display("FAIL wd_start_hold: got %b want %b", outs_b(), O_HOLD); end
        tick();
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            total++;
            if (hz_b.ctrl_state !== 2'd1 || hz_b.muldiv_error !== 1'b0) begin
                bad++; $display("FAIL wd_wait[%0d]: state=%0d err=%b want state=1 err=0", w, hz_b.ctrl_state, hz_b.muldiv_error);
            end
            tick();
        end
        ex_muldiv_start = 1'b0;
        @(negedge clk);
        total++;
        if (hz_b.muldiv_error !== 1'b1) begin bad++; $display("FAIL wd_pulse: got %b want 1", hz_b.muldiv_error); end
        total++;
        if (hz_b.ctrl_state !== 2'd0) begin bad++; $display("FAIL wd_state: got %0d want 0", hz_b.ctrl_state); end
        tick();
        @(negedge clk);
        total++;
        if (hz_b.muldiv_error !== 1'b0) begin bad++; $display("FAIL wd_single_pulse: got %b want 0", hz_b.muldiv_error); end
        tick();
    endtask

    task automatic test_branch_mem_busy();
        do_reset();
        ex_branch_taken = 1'b1; dmem_busywait = 1'b1;
        @(negedge clk);
        total++;
        if (outs_a() !== O_HOLD) begin bad++; $display("FAIL bmb_first_hold: got %b want %b", outs_a(), O_HOLD); end
        tick();
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            total++;
            if (hz_a.ctrl_state !== 2'd2 || outs_a() !== O_HOLD) begin
                bad++; $display("FAIL bmb_pending[%0d]: state=%0d outs=%b want state=2 outs=%b", c, hz_a.ctrl_state, outs_a(), O_HOLD);
            end
            tick();
        end
        dmem_busywait = 1'b0;
        @(negedge clk);
        total++;
        if (hz_a.ctrl_state !== 2'd2 || outs_a() !== O_FLUSH) begin
            bad++; $display("FAIL bmb_flush: state=%0d outs=%b want state=2 outs=%b", hz_a.ctrl_state, outs_a(), O_FLUSH);
        end
        tick();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        total++;
        if (hz_a.ctrl_state !== 2'd0 || outs_a() !== O_IDLE) begin
            bad++; $display("FAIL bmb_run: state=%0d outs=%b want state=0 outs=%b", hz_a.ctrl_state, outs_a(), O_IDLE);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        ex_muldiv_start = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++;
        if (hz_a.ctrl_state !== 2'd1) begin bad++; $display("FAIL rmw_in_wait: got %0d want 1", hz_a.ctrl_state); end
        reset = 1'b0;
        #1;
        total++;
        if (outs_a() !== O_FLUSH) begin bad++; $display("FAIL rmw_reset_outs: got %b want %b", outs_a(), O_FLUSH); end
        tick();
        @(negedge clk);
        total++;
        if (hz_a.ctrl_state !== 2'd0 || hz_a.muldiv_error !== 1'b0) begin
            bad++; $display("FAIL rmw_after_reset: state=%0d err=%b want state=0 err=0", hz_a.ctrl_state, hz_a.muldiv_error);
        end
`ifdef HAZARD_STALL_COUNTERS_EN
        total++;
        if (stall_a !== 32'd0 || flush_a !== 32'd0) begin
            bad++; $display("FAIL rmw_counters: stall=%0d flush=%0d want 0 0", stall_a, flush_a);
        end
`endif
        reset = 1'b1;
        ex_muldiv_start = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if (hz_a.muldiv_error !== 1'b0) begin bad++; $display("FAIL rmw_no_pulse: got %b want 0", hz_a.muldiv_error); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_over_load_use();
        test_mem_busy();
        test_muldiv();
        test_watchdog();
        test_branch_mem_busy();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
